// File: rtl/tx_buff.sv
// CAN transmit staging buffer.
// Holds one standard-ID frame (2 header bytes + up to 8 data bytes) written
// byte-by-byte by the host. Once every byte the frame needs is loaded, the
// buffer locks and starts the frame generator. It stays locked until the
// generator reports a successful transmission.
// Build option: TX_BUFF_SUCCESS_CLR_EN also zeroes all bytes on release.
//
// Handshake semantics: a tx_buff_ld bit is a write request that is accepted
// on a rising edge only while tx_buff_busy is 0. frame_gen_intl is a
// one-cycle start pulse to the generator. tx_success is honoured only while
// tx_buff_busy is 1, and it releases the buffer on that edge.
module tx_buff #(
    parameter int NUM_BYTES = 10,
    parameter int MAX_DATA  = 8
) (
    input  logic                 clk,
    input  logic                 g_rst,
    input  logic [7:0]           data_in,
    input  logic [NUM_BYTES-1:0] tx_buff_ld,
    input  logic                 tx_success,
    output logic                 frame_gen_intl,
    output logic                 tx_buff_busy,
    output logic [7:0]           tx_buff_1,
    output logic [7:0]           tx_buff_2,
    output logic [7:0]           tx_buff_3,
    output logic [7:0]           tx_buff_4,
    output logic [7:0]           tx_buff_5,
    output logic [7:0]           tx_buff_6,
    output logic [7:0]           tx_buff_7,
    output logic [7:0]           tx_buff_8,
    output logic [7:0]           tx_buff_9,
    output logic [7:0]           tx_buff_10,
    output logic                 rtr,
    output logic [3:0]           dlc
);

    localparam logic [3:0] MAX_DLC = 4'(MAX_DATA);

    logic [7:0]           buff_q [NUM_BYTES];
    logic [7:0]           buff_d [NUM_BYTES];
    logic [NUM_BYTES-1:0] loaded_q;
    logic [NUM_BYTES-1:0] loaded_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 intl_q;
    logic                 intl_d;

    logic [3:0]           need;
    logic [NUM_BYTES-1:0] req_mask;
    logic                 complete;

    // Next-state: accept writes when unlocked, detect completion on the
    // next-state mask/header, or release on tx_success when locked.
    always_comb begin
        for (int k = 0; k < NUM_BYTES; k++) begin
            buff_d[k] = buff_q[k];
        end
        loaded_d = loaded_q;
        busy_d   = busy_q;
        intl_d   = 1'b0;
        need     = 4'd0;
        req_mask = '0;
        complete = 1'b0;

        if (busy_q) begin
            if (tx_success) begin
                busy_d   = 1'b0;
                loaded_d = '0;
`ifdef TX_BUFF_SUCCESS_CLR_EN
                for (int k = 0; k < NUM_BYTES; k++) begin
                    buff_d[k] = 8'h00;
                end
`endif
            end
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (tx_buff_ld[k]) begin
                    buff_d[k]   = data_in;
                    loaded_d[k] = 1'b1;
                end
            end

            // Remote frames carry no data; oversize DLC codes mean 8 bytes.
            if (buff_d[1][4]) begin
                need = 4'd0;
            end else if (buff_d[1][3:0] > MAX_DLC) begin
                need = MAX_DLC;
            end else begin
                need = buff_d[1][3:0];
            end

            req_mask[0] = 1'b1;
            req_mask[1] = 1'b1;
            for (int i = 2; i < NUM_BYTES; i++) begin
                req_mask[i] = ((i - 2) < int'(need));
            end

            complete = &(loaded_d | ~req_mask);
            if (complete) begin
                busy_d = 1'b1;
                intl_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (g_rst) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                buff_q[k] <= 8'h00;
            end
            loaded_q <= '0;
            busy_q   <= 1'b0;
            intl_q   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                buff_q[k] <= buff_d[k];
            end
            loaded_q <= loaded_d;
            busy_q   <= busy_d;
            intl_q   <= intl_d;
        end
    end

    assign frame_gen_intl = intl_q;
    assign tx_buff_busy   = busy_q;
    assign tx_buff_1      = buff_q[0];
    assign tx_buff_2      = buff_q[1];
    assign tx_buff_3      = buff_q[2];
    assign tx_buff_4      = buff_q[3];
    assign tx_buff_5      = buff_q[4];
    assign tx_buff_6      = buff_q[5];
    assign tx_buff_7      = buff_q[6];
    assign tx_buff_8      = buff_q[7];
    assign tx_buff_9      = buff_q[8];
    assign tx_buff_10     = buff_q[9];
    assign rtr            = buff_q[1][4];
    assign dlc            = buff_q[1][3:0];

endmodule

// File: tb/tb_tx_buff.sv
// Testbench for tx_buff: directed scenarios followed by randomized traffic,
// all outputs compared each cycle against a frame-level reference model.
module tb_tx_buff;

  logic       clk;
  logic       g_rst;
  logic [7:0] data_in;
  logic [9:0] tx_buff_ld;
  logic       tx_success;
  logic       frame_gen_intl;
  logic       tx_buff_busy;
  logic [7:0] dut_b [10];
  logic       rtr;
  logic [3:0] dlc;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0] m_b [10];
  bit         m_loaded [10];
  bit         m_busy;
  bit         m_pulse;

  logic [7:0] snap_b [10];
  logic       snap_busy;

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  tx_buff dut (
    .clk            (clk),
    .g_rst          (g_rst),
    .data_in        (data_in),
    .tx_buff_ld     (tx_buff_ld),
    .tx_success     (tx_success),
    .frame_gen_intl (frame_gen_intl),
    .tx_buff_busy   (tx_buff_busy),
    .tx_buff_1      (dut_b[0]),
    .tx_buff_2      (dut_b[1]),
    .tx_buff_3      (dut_b[2]),
    .tx_buff_4      (dut_b[3]),
    .tx_buff_5      (dut_b[4]),
    .tx_buff_6      (dut_b[5]),
    .tx_buff_7      (dut_b[6]),
    .tx_buff_8      (dut_b[7]),
    .tx_buff_9      (dut_b[8]),
    .tx_buff_10     (dut_b[9]),
    .rtr            (rtr),
    .dlc            (dlc)
  );

  // ---------------- reference model ----------------
  function automatic int need_bytes();
    int d;
    d = int'(m_b[1][3:0]);
    if (m_b[1][4]) return 0;
    if (d > 8) return 8;
    return d;
  endfunction

  task automatic model_edge(input bit rst, input logic [7:0] d,
                            input logic [9:0] ld, input bit succ);
    bit all_in;
    if (rst) begin
      for (int k = 0; k < 10; k++) begin
        m_b[k] = 8'h00;
        m_loaded[k] = 1'b0;
      end
      m_busy  = 1'b0;
      m_pulse = 1'b0;
    end else if (m_busy) begin
      m_pulse = 1'b0;
      if (succ) begin
        m_busy = 1'b0;
        for (int k = 0; k < 10; k++) begin
          m_loaded[k] = 1'b0;
`ifdef TX_BUFF_SUCCESS_CLR_EN
          m_b[k] = 8'h00;
`endif
        end
      end
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (ld[k]) begin
          m_b[k] = d;
          m_loaded[k] = 1'b1;
        end
      end
      all_in = m_loaded[0] && m_loaded[1];
      for (int n = 0; n < need_bytes(); n++) begin
        if (!m_loaded[2 + n]) all_in = 1'b0;
      end
      m_busy  = all_in;
      m_pulse = all_in;
    end
  endtask

  // ---------------- scoreboard / checks ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s tx_buff_%0d", tag, k + 1), dut_b[k], m_b[k]);
    end
    chk({tag, " busy"}, {7'd0, tx_buff_busy}, {7'd0, m_busy});
    chk({tag, " frame_gen_intl"}, {7'd0, frame_gen_intl}, {7'd0, m_pulse});
    chk({tag, " rtr"}, {7'd0, rtr}, {7'd0, m_b[1][4]});
    chk({tag, " dlc"}, {4'd0, dlc}, {4'd0, m_b[1][3:0]});
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit rst, input logic [7:0] d,
                      input logic [9:0] ld, input bit succ);
    @(negedge clk);
    g_rst      = rst;
    data_in    = d;
    tx_buff_ld = ld;
    tx_success = succ;
    @(posedge clk);
    model_edge(rst, d, ld, succ);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 8'h00, 10'h000, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] ld;
    logic [7:0] d;
    bit rst;
    bit succ;

    g_rst = 1'b1; data_in = 8'h00; tx_buff_ld = 10'h000; tx_success = 1'b0;
    for (int k = 0; k < 10; k++) begin
      m_b[k] = 8'h00;
      m_loaded[k] = 1'b0;
    end
    m_busy = 1'b0;
    m_pulse = 1'b0;

    // reset priority over a strobe
    step("reset", 1'b1, 8'h01, 10'h001, 1'b0);
    chk("reset tx_buff_1 lit", dut_b[0], 8'h00);
    chk("reset busy lit", {7'd0, tx_buff_busy}, 8'h00);
    chk("reset intl lit", {7'd0, frame_gen_intl}, 8'h00);
    idle("post_reset");

    // partial fill, dlc=A needs 8 data bytes
    step("pf1", 1'b0, 8'h01, 10'h001, 1'b0);
    step("pf2", 1'b0, 8'hAA, 10'h002, 1'b0);
    step("pf3", 1'b0, 8'hCC, 10'h004, 1'b0);
    step("pf4", 1'b0, 8'hAB, 10'h008, 1'b0);
    chk("pf tx_buff_4 lit", dut_b[3], 8'hAB);
    chk("pf dlc lit", {4'd0, dlc}, 8'h0A);
    chk("pf busy lit", {7'd0, tx_buff_busy}, 8'h00);
    idle("pf_idle");
    step("pf_rst", 1'b1, 8'h00, 10'h000, 1'b0);

    // remote frame: two header bytes suffice
    step("rtr1", 1'b0, 8'h12, 10'h001, 1'b0);
    chk("rtr1 intl lit", {7'd0, frame_gen_intl}, 8'h00);
    step("rtr2", 1'b0, 8'h35, 10'h002, 1'b0);
    chk("rtr2 intl lit", {7'd0, frame_gen_intl}, 8'h01);
    chk("rtr2 busy lit", {7'd0, tx_buff_busy}, 8'h01);
    idle("rtr_hold");
    chk("rtr_hold intl lit", {7'd0, frame_gen_intl}, 8'h00);
    chk("rtr_hold busy lit", {7'd0, tx_buff_busy}, 8'h01);
    step("rtr_rel", 1'b0, 8'h00, 10'h000, 1'b1);
    chk("rtr_rel busy lit", {7'd0, tx_buff_busy}, 8'h00);

    // data frame dlc=2, header byte 2 written first
    step("d2_b2", 1'b0, 8'h02, 10'h002, 1'b0);
    step("d2_b1", 1'b0, 8'h11, 10'h001, 1'b0);
    step("d2_b3", 1'b0, 8'h33, 10'h004, 1'b0);
    chk("d2_b3 intl lit", {7'd0, frame_gen_intl}, 8'h00);
    step("d2_b4", 1'b0, 8'h44, 10'h008, 1'b0);
    chk("d2_b4 intl lit", {7'd0, frame_gen_intl}, 8'h01);
    step("d2_locked", 1'b0, 8'hFF, 10'h004, 1'b0);
    chk("d2_locked tx_buff_3 lit", dut_b[2], 8'h33);

    // release with a same-cycle strobe that must be ignored
    step("rel", 1'b0, 8'h55, 10'h001, 1'b1);
    chk("rel busy lit", {7'd0, tx_buff_busy}, 8'h00);
    step("rel_wr", 1'b0, 8'h77, 10'h001, 1'b0);
    chk("rel_wr tx_buff_1 lit", dut_b[0], 8'h77);
`ifdef TX_BUFF_SUCCESS_CLR_EN
    chk("rel_wr tx_buff_2 lit", dut_b[1], 8'h00);
`else
    chk("rel_wr tx_buff_2 lit", dut_b[1], 8'h02);
`endif

    // stray success while unlocked
    for (int k = 0; k < 10; k++) snap_b[k] = dut_b[k];
    snap_busy = tx_buff_busy;
    step("stray", 1'b0, 8'h99, 10'h000, 1'b1);
    for (int k = 0; k < 10; k++) chk($sformatf("stray snap %0d", k + 1), dut_b[k], snap_b[k]);
    chk("stray busy snap", {7'd0, tx_buff_busy}, {7'd0, snap_busy});

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      d    = 8'($urandom);
      rst  = ($urandom_range(0, 79) == 0);
      succ = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: ld = 10'(1) << $urandom_range(0, 9);
        6:                ld = 10'h000;
        7:                ld = 10'($urandom);
        default:          ld = 10'h002;
      endcase
      step("rand", rst, d, ld, succ);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
